// File: rtl/binary_down_cnt_struct_pkg.sv
// binary_down_cnt_struct_pkg: shared encodings and defaults for the structural down counter
package binary_down_cnt_struct_pkg;
    localparam int DEF_WIDTH = 4;
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    typedef enum logic {ST_RUN = 1'b0, ST_DONE = 1'b1} state_t;
endpackage

// File: rtl/binary_down_cnt_struct_dff.sv
// dff_struct: single-bit D flop; any reset is built into the D path by the caller
//   clk : rising-edge clock
//   d   : next value
//   q   : stored value
module dff_struct (
    input  logic clk,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk)
        q <= d;
endmodule

// File: rtl/binary_down_cnt_struct_sub_by_one_borrow.sv
// sub_by_one_borrow: ripple of half-subtractor cells computing in1 - bin
//   in1  : operand
//   bin  : borrow in (subtract one when high, pass through when low)
//   out  : difference, modulo 2^WIDTH
//   bout : borrow out, high exactly when bin=1 and in1=0
module sub_by_one_borrow
    import binary_down_cnt_struct_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] in1,
    input  logic             bin,
    output logic [WIDTH-1:0] out,
    output logic             bout
);
    logic [WIDTH:0] b;
    assign b[0] = bin;
    assign bout = b[WIDTH];
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic n_in;
        xor (out[i], in1[i], b[i]);
        not (n_in, in1[i]);
        and (b[i+1], n_in, b[i]);
    end
endmodule

// File: rtl/binary_down_cnt_struct.sv
// binary_down_cnt_struct: loadable structural down counter with terminal-count pulse
//   clk, rst : clock and synchronous active-high reset
//   en       : decrement enable
//   load     : load strobe (beats en), load_val is captured into cnt and reload_reg
//   mode     : 00 WRAP, 01 RELOAD, 10 ONESHOT, 11 behaves as WRAP
//   cnt      : registered count; zero : combinational cnt == 0
//   tc       : registered one-cycle terminal-count pulse; done : ONESHOT expiry flag
module binary_down_cnt_struct
    import binary_down_cnt_struct_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] cnt,
    output logic             zero,
    output logic             tc,
    output logic             done
);
    logic [WIDTH-1:0] dec, cnt_d, reload_q, reload_d;
    logic bout, n_rst, n_load, keep, is_os, is_rl, sel_rl, sel_os, n_sel_rl, n_sel_os;
    logic in_done, tc_kill, n_tc_kill, tc_d, done_or, done_d, st_q, st_or, st_d;
    state_t state;

    // With bin=en the decrementer passes cnt through when idle, so hold needs no extra mux,
    // and on borrow it already yields all ones for WRAP.
    sub_by_one_borrow #(.WIDTH(WIDTH)) u_dec (.in1(cnt), .bin(en), .out(dec), .bout(bout));

    assign is_os   = mode == MODE_ONESHOT;
    assign is_rl   = mode == MODE_RELOAD;
    assign state   = state_t'(st_q);
    assign in_done = state == ST_DONE;
    assign zero    = ~|cnt;

    not (n_rst, rst);
    not (n_load, load);
    and (keep, n_rst, n_load);
    and (sel_rl, bout, is_rl);
    and (sel_os, bout, is_os);
    not (n_sel_rl, sel_rl);
    not (n_sel_os, sel_os);

    // A borrow in ONESHOT after expiry stays silent; other modes pulse even with done set.
    and (tc_kill, is_os, in_done);
    not (n_tc_kill, tc_kill);
    and (tc_d, keep, bout, n_tc_kill);
    or  (done_or, done, sel_os);
    and (done_d, keep, done_or);
    or  (st_or, st_q, sel_os);
    and (st_d, keep, st_or);

    dff_struct u_tc   (.clk(clk), .d(tc_d),   .q(tc));
    dff_struct u_done (.clk(clk), .d(done_d), .q(done));
    dff_struct u_st   (.clk(clk), .d(st_d),   .q(st_q));

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic a, b, c, pick, l1, l2, m, r2, rm;
        and (a, dec[i], n_sel_os);
        and (c, a, n_sel_rl);
        and (b, reload_q[i], sel_rl);
        or  (pick, b, c);
        and (l1, load, load_val[i]);
        and (l2, n_load, pick);
        or  (m, l1, l2);
        or  (cnt_d[i], rst, m);
        and (r2, n_load, reload_q[i]);
        or  (rm, l1, r2);
        or  (reload_d[i], rst, rm);
        dff_struct u_cnt (.clk(clk), .d(cnt_d[i]),    .q(cnt[i]));
        dff_struct u_rl  (.clk(clk), .d(reload_d[i]), .q(reload_q[i]));
    end
endmodule

// File: tb/tb_binary_down_cnt_struct.sv
// tb_binary_down_cnt_struct: directed vectors with a queue scoreboard for binary_down_cnt_struct
module tb_binary_down_cnt_struct;
    logic       clk = 0;
    logic       rst = 0, en = 0, load = 0;
    logic [3:0] load_val = 0;
    logic [1:0] mode = 0;
    logic [3:0] cnt;
    logic       zero, tc, done;
    logic [6:0] exp_q[$];
    int         pass_cnt = 0, total = 0, step_no = 0, pop_no = 0;

    binary_down_cnt_struct #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .mode(mode), .cnt(cnt), .zero(zero), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic l, input logic e, input logic [3:0] v,
                        input logic [1:0] m, input logic [3:0] ec, input logic et, input logic ed);
        @(negedge clk);
        #1;
        rst = r; load = l; en = e; load_val = v; mode = m;
        exp_q.push_back({ec, ec == 4'h0, et, ed});
        step_no++;
    endtask

    // Monitor: outputs settle after each rising edge; compare on the falling edge.
    initial forever begin
        @(negedge clk);
        if (exp_q.size() != 0) begin
            logic [6:0] e, a;
            e = exp_q.pop_front();
            a = {cnt, zero, tc, done};
            pop_no++;
            total++;
            if (a === e) pass_cnt++;
            else $display("FAIL step%0d {cnt,zero,tc,done}: got %h,%b,%b,%b expected %h,%b,%b,%b",
                          pop_no, a[6:3], a[2], a[1], a[0], e[6:3], e[2], e[1], e[0]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step(1, 0, 0, 0, 0, 4'hF, 0, 0);
        for (int i = 14; i >= 0; i--) step(0, 0, 1, 0, 0, 4'(i), 0, 0);
        step(0, 0, 1, 0, 0, 4'hF, 1, 0);
        step(0, 1, 1, 5, 0, 4'h5, 0, 0);
        for (int i = 4; i >= 0; i--) step(0, 0, 1, 0, 0, 4'(i), 0, 0);
        step(0, 1, 1, 3, 1, 4'h3, 0, 0);
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 1, 0, 1, 4'h2, 0, 0);
            step(0, 0, 1, 0, 1, 4'h1, 0, 0);
            step(0, 0, 1, 0, 1, 4'h0, 0, 0);
            step(0, 0, 1, 0, 1, 4'h3, 1, 0);
        end
        step(0, 1, 0, 2, 2, 4'h2, 0, 0);
        step(0, 0, 1, 0, 2, 4'h1, 0, 0);
        step(0, 0, 1, 0, 2, 4'h0, 0, 0);
        step(0, 0, 1, 0, 2, 4'h0, 1, 1);
        step(0, 0, 1, 0, 2, 4'h0, 0, 1);
        step(0, 0, 1, 0, 2, 4'h0, 0, 1);
        step(0, 0, 1, 0, 0, 4'hF, 1, 1);
        step(0, 1, 0, 1, 2, 4'h1, 0, 0);
        step(0, 0, 1, 0, 2, 4'h0, 0, 0);
        step(0, 0, 1, 0, 2, 4'h0, 1, 1);
        step(0, 1, 0, 9, 0, 4'h9, 0, 0);
        step(0, 0, 1, 0, 0, 4'h8, 0, 0);
        step(0, 0, 1, 0, 0, 4'h7, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 4'h7, 0, 0);
        step(1, 0, 1, 0, 0, 4'hF, 0, 0);
        step(0, 1, 0, 0, 1, 4'h0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, 4'h0, 1, 0);
        step(0, 0, 0, 0, 1, 4'h0, 0, 0);
        step(0, 1, 0, 1, 2, 4'h1, 0, 0);
        step(0, 0, 1, 0, 2, 4'h0, 0, 0);
        step(0, 0, 1, 0, 2, 4'h0, 1, 1);
        step(1, 0, 1, 0, 2, 4'hF, 0, 0);
        @(negedge clk);
        #2;
        total++;
        if (exp_q.size() == 0 && pop_no == step_no) pass_cnt++;
        else $display("FAIL drain: %0d pending, %0d checked, %0d issued", exp_q.size(), pop_no, step_no);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/binary_down_cnt_struct.md
Name: binary_down_cnt_struct

Overview:
- Structural loadable binary down counter with terminal-count signalling.
- It is the count-down companion to the team's structural up counter: same add-by-one/flop style, opposite direction.
- Used as a programmable delay/timeout source. A controller loads a value, enables counting, and watches `tc`/`done`.

Parameters:
- WIDTH, 4, counter width in bits (all count ports and registers are WIDTH wide).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  count enable; one decrement step per cycle while high.
- load  in  1  load strobe; takes priority over en.
- load_val  in  WIDTH  value captured on load.
- mode  in  2  00=WRAP, 01=RELOAD, 10=ONESHOT, 11=reserved (treated as WRAP).
- cnt  out  WIDTH  current count (registered).
- zero  out  1  combinational, cnt == 0.
- tc  out  1  registered one-cycle terminal-count pulse.
- done  out  1  registered; ONESHOT expiry flag.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising clk edge. Values after reset:
  - cnt = all ones (4'hF at default).
  - reload_reg = all ones.
  - tc = 0, done = 0, state = RUN.
- Reset is muxed into the D path of every flop, so no flop sees an asynchronous clear.
- Priority per edge: rst > load > en > hold.
- Load (load=1):
  - cnt <= load_val, reload_reg <= load_val.
  - tc <= 0, done <= 0, state <= RUN.
  - en is ignored that cycle.
- Decrement (en=1, load=0, cnt != 0): cnt <= cnt - 1, tc <= 0.
- Borrow event (en=1, load=0, cnt == 0):
  - WRAP: cnt <= all ones; tc <= 1 for exactly one cycle.
  - RELOAD: cnt <= reload_reg; tc <= 1 for one cycle. If reload_reg is 0, the counter stays at 0 and tc pulses every enabled cycle.
  - ONESHOT, state RUN: cnt holds 0; tc <= 1 once; done <= 1; state <= DONE.
  - ONESHOT, state DONE: cnt holds 0; tc stays 0; done stays 1. Only load or rst returns state to RUN.
- Hold (en=0, load=0): cnt, done and state unchanged; tc <= 0.
- Latency:
  - tc rises the cycle after the edge at which cnt==0 and en=1 were sampled.
  - zero reflects cnt combinationally (zero-cycle latency).
- Mode changes are sampled every cycle and take effect at the next borrow event. Switching away from ONESHOT while in DONE leaves done=1 until load or rst.
- Width rule: arithmetic is modulo 2^WIDTH. Borrow-out of the decrementer is exactly the "cnt==0 and en" condition; no separate comparator is used for tc.
- Simultaneous load and en: load wins; the first decrement happens on the next enabled cycle.
- Reset mid-count: on the next edge, cnt=all ones and done=0 regardless of mode or state.

Decomposition:
- Shared package holds:
  - Mode encodings: MODE_WRAP=2'b00, MODE_RELOAD=2'b01, MODE_ONESHOT=2'b10.
  - ONESHOT state encoding: ST_RUN=1'b0, ST_DONE=1'b1.
  - Default WIDTH=4.
- One natural sub-module: sub_by_one_borrow.
  - Inputs in1[WIDTH-1:0], bin; outputs out[WIDTH-1:0], bout.
  - Ripple of half-subtractor cells, mirroring add_by_one_carry.
  - bin is driven by en; bout feeds the borrow-event logic.
- State bits (cnt, reload_reg, tc, done, state) are stored in dff_struct instances, one per bit. The next-state muxes are built from gate primitives.

Test Plan:
1. Reset then count: rst=1 for 1 cycle, then en=1 for 16 cycles, mode=WRAP. Required: cnt runs F,E,…,1,0,F; tc=1 only in the cycle cnt shows F after 0; zero=1 only while cnt=0.
2. Load priority: load=1, en=1, load_val=5 in the same cycle. Required: next cnt=5, not 4. Then en=1 for 5 cycles gives 4,3,2,1,0 with tc=0 throughout.
3. RELOAD: load_val=3, mode=RELOAD, en=1 continuously. Required: cnt sequence 3,2,1,0,3,2,1,0; tc pulses once per period, in the cycle cnt returns to 3.
4. ONESHOT: load_val=2, mode=ONESHOT, en=1 for 6 cycles. Required: cnt 2,1,0,0,0,0; tc high for exactly one cycle (the first cycle after the 0 is sampled); done=1 from then on. A subsequent load_val=1 clears done and the counter runs again.
5. Hold and mid-operation reset: load 9, en=1 for 2 cycles (cnt=7), en=0 for 3 cycles. Required: cnt holds 7 and tc=0. Then rst=1 with en=1: next cnt=F, done=0, tc=0.
6. Edge case RELOAD with reload value 0: load_val=0, mode=RELOAD, en=1 for 3 cycles. Required: cnt stays 0 and tc=1 each cycle following an enabled sample.
